seg_sequencer: RTL and testbench

SEG_SEQUENCER -- requirements
Module: seg_sequencer

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_tick_gen.sv | 36 +++
 rtl/seg_sequencer.sv | 133 +++++++++++++
 tb/tb_seg_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the segway power/soft-start sequencer.
//   seg_state_e      - sequencer state encoding
//   SS_MAX           - full-scale soft-start value
//   SS_DIV_W_DEF     - default soft-start prescaler width
//   STEER_DLY_W_DEF  - default steer-qualify counter width
package seg_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_WAIT    = 3'd1,
    ST_RAMP_UP = 3'd2,
    ST_RUN     = 3'd3,
    ST_RAMP_DN = 3'd4
  } seg_state_e;

  localparam logic [7:0] SS_MAX          = 8'hFF;
  localparam int         SS_DIV_W_DEF    = 9;
  localparam int         STEER_DLY_W_DEF = 12;

endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: free-running prescaler producing one tick every 2^DIV_W
// enabled clocks.
//   clk, rst_n - system clock, async active-low reset
//   clr        - synchronous clear (wins over en)
//   en         - count enable
//   tick       - high for the one cycle the prescaler sits at all-ones
module seg_tick_gen
  import seg_pkg::*;
#(
  parameter int DIV_W = SS_DIV_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clr)     div_d = '0;
    else if (en) div_d = div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  // Counting from zero, the all-ones value is reached on the 2^DIV_W-th
  // clock, so the consumer's update lands exactly 2^DIV_W clocks after clear.
  assign tick = en && (div_q == '1);

endmodule

// File: rtl/seg_sequencer.sv
// seg_sequencer: power-up / soft-start / steering-enable sequencer.
//   clk, rst_n - system clock, async active-low reset
//   pwr_btn    - one-cycle power-toggle request
//   rider_on   - rider weight present (level)
//   steer_ok   - load cells balanced enough for steering (level)
//   too_fast   - overspeed flag
//   pwr_up     - datapath power enable
//   ss_tmr     - soft-start scale 0x00..0xFF
//   en_steer   - steering enable
//   ovr_alarm  - registered overspeed alarm
//
// state      | meaning
// OFF        | datapath unpowered, ss_tmr 0
// WAIT       | powered, waiting for rider, ss_tmr 0
// RAMP_UP    | ss_tmr climbing one step per tick
// RUN        | ss_tmr held full scale, steering may be enabled
// RAMP_DN    | ss_tmr falling one step per tick, then OFF or WAIT
module seg_sequencer
  import seg_pkg::*;
#(
  parameter int SS_DIV_W    = SS_DIV_W_DEF,
  parameter int STEER_DLY_W = STEER_DLY_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_btn,
  input  logic       rider_on,
  input  logic       steer_ok,
  input  logic       too_fast,
  output logic       pwr_up,
  output logic [7:0] ss_tmr,
  output logic       en_steer,
  output logic       ovr_alarm
);

  seg_state_e             state_q, state_d;
  logic [7:0]             ss_q, ss_d;
  logic                   off_req_q, off_req_d;
  logic [STEER_DLY_W-1:0] steer_cnt_q, steer_cnt_d;
  logic                   pwr_up_q, pwr_up_d;
  logic                   en_steer_q, en_steer_d;
  logic                   ovr_alarm_q, ovr_alarm_d;
  logic                   state_chg, ramp_en, tick, steer_sat;

  assign state_chg = (state_d != state_q);
  assign ramp_en   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DN);
  assign steer_sat = (steer_cnt_q == '1);

  seg_tick_gen #(.DIV_W(SS_DIV_W)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_chg),
    .en    (ramp_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    off_req_d = off_req_q;
    case (state_q)
      ST_OFF: if (pwr_btn) state_d = ST_WAIT;
      ST_WAIT: begin
        if (pwr_btn)       state_d = ST_OFF;
        else if (rider_on) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (pwr_btn || !rider_on) begin
          state_d = ST_RAMP_DN;
          if (pwr_btn) off_req_d = 1'b1;
        end else if (ss_q == SS_MAX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pwr_btn || !rider_on) begin
          state_d = ST_RAMP_DN;
          if (pwr_btn) off_req_d = 1'b1;
        end
      end
      ST_RAMP_DN: begin
        if (pwr_btn) off_req_d = 1'b1;
        // A press in the final cycle still counts toward powering off.
        if (ss_q == 8'h00) state_d = (off_req_q || pwr_btn) ? ST_OFF : ST_WAIT;
      end
      default: state_d = ST_OFF;
    endcase
    if (state_d == ST_OFF || state_d == ST_WAIT) off_req_d = 1'b0;
  end

  // Steps are skipped in a leaving cycle so a ramp reversal resumes from the
  // exact current value.
  always_comb begin
    ss_d = ss_q;
    if (tick && !state_chg) begin
      if (state_q == ST_RAMP_UP && ss_q != SS_MAX)      ss_d = ss_q + 8'd1;
      else if (state_q == ST_RAMP_DN && ss_q != 8'h00)  ss_d = ss_q - 8'd1;
    end
  end

  always_comb begin
    steer_cnt_d = '0;
    if (state_q == ST_RUN && steer_ok) steer_cnt_d = steer_sat ? steer_cnt_q : steer_cnt_q + 1'b1;
    pwr_up_d    = (state_d != ST_OFF);
    en_steer_d  = (state_d == ST_RUN) && steer_sat && !too_fast;
    ovr_alarm_d = too_fast && pwr_up_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      ss_q        <= 8'h00;
      off_req_q   <= 1'b0;
      steer_cnt_q <= '0;
      pwr_up_q    <= 1'b0;
      en_steer_q  <= 1'b0;
      ovr_alarm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_q        <= ss_d;
      off_req_q   <= off_req_d;
      steer_cnt_q <= steer_cnt_d;
      pwr_up_q    <= pwr_up_d;
      en_steer_q  <= en_steer_d;
      ovr_alarm_q <= ovr_alarm_d;
    end
  end

  assign pwr_up    = pwr_up_q;
  assign ss_tmr    = ss_q;
  assign en_steer  = en_steer_q;
  assign ovr_alarm = ovr_alarm_q;

endmodule

// File: tb/tb_seg_sequencer.sv
// tb_seg_sequencer: vector table, directed ramp/steer/reset sequences and a
// randomized run against a behavioural model of the sequencer rules.
module tb_seg_sequencer;

  localparam int SDW    = 2;
  localparam int STW    = 3;
  localparam int PERIOD = 1 << SDW;
  localparam int SMAX   = (1 << STW) - 1;

  localparam int M_OFF = 0, M_WAIT = 1, M_UP = 2, M_RUN = 3, M_DN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwr_btn = 1'b0, rider_on = 1'b0, steer_ok = 1'b0, too_fast = 1'b0;
  logic       pwr_up, en_steer, ovr_alarm;
  logic [7:0] ss_tmr;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seg_sequencer #(.SS_DIV_W(SDW), .STEER_DLY_W(STW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_btn   (pwr_btn),
    .rider_on  (rider_on),
    .steer_ok  (steer_ok),
    .too_fast  (too_fast),
    .pwr_up    (pwr_up),
    .ss_tmr    (ss_tmr),
    .en_steer  (en_steer),
    .ovr_alarm (ovr_alarm)
  );

  typedef struct packed {
    logic       btn;
    logic       rider;
    logic       steer;
    logic       tf;
    logic       pwr;
    logic [7:0] ss;
    logic       en;
    logic       al;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input bit b, r, s, t, p, input logic [7:0] ss, input bit e, a);
    vec_t v;
    v.btn = b; v.rider = r; v.steer = s; v.tf = t;
    v.pwr = p; v.ss = ss; v.en = e; v.al = a;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pwr_btn = 1'b0; rider_on = 1'b0; steer_ok = 1'b0; too_fast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ss(input logic [7:0] target, input int limit, output int n, output bit pwr_ok);
    n = 0;
    pwr_ok = 1'b1;
    while (ss_tmr !== target && n < limit) begin
      cyc();
      n++;
      if (pwr_up !== 1'b1) pwr_ok = 1'b0;
    end
  endtask

  // Behavioural model: ramp steps happen every PERIOD clocks of residence
  // in a ramp state; steering needs SMAX consecutive qualified RUN clocks.
  int m_mode, m_lvl, m_age, m_steer;
  bit m_off, m_pwr, m_en, m_al;

  task automatic model_reset();
    m_mode = M_OFF; m_lvl = 0; m_age = 0; m_steer = 0;
    m_off = 0; m_pwr = 0; m_en = 0; m_al = 0;
  endtask

  task automatic model_step();
    int nxt, lvl_n;
    bit off_n, step;
    nxt   = m_mode;
    lvl_n = m_lvl;
    off_n = m_off;
    step  = ((m_age % PERIOD) == PERIOD - 1);
    case (m_mode)
      M_OFF:  if (pwr_btn) nxt = M_WAIT;
      M_WAIT: if (pwr_btn) nxt = M_OFF; else if (rider_on) nxt = M_UP;
      M_UP: begin
        if (pwr_btn || !rider_on) begin nxt = M_DN; off_n = pwr_btn; end
        else if (m_lvl == 255) nxt = M_RUN;
        else if (step) lvl_n = m_lvl + 1;
      end
      M_RUN: if (pwr_btn || !rider_on) begin nxt = M_DN; off_n = pwr_btn; end
      M_DN: begin
        if (pwr_btn) off_n = 1;
        if (m_lvl == 0) nxt = off_n ? M_OFF : M_WAIT;
        else if (step) lvl_n = m_lvl - 1;
      end
      default: nxt = M_OFF;
    endcase
    if (nxt == M_OFF || nxt == M_WAIT) begin off_n = 0; lvl_n = 0; end
    m_en    = (nxt == M_RUN) && (m_steer >= SMAX) && !too_fast;
    m_steer = (m_mode == M_RUN && steer_ok) ? ((m_steer < SMAX) ? m_steer + 1 : SMAX) : 0;
    m_age   = (nxt == m_mode) ? m_age + 1 : 0;
    m_pwr   = (nxt != M_OFF);
    m_al    = too_fast && m_pwr;
    m_mode  = nxt;
    m_lvl   = lvl_n;
    m_off   = off_n;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    logic [7:0] prev;

    //               b r s t  p  ss     e a
    vecs[0]  = mk(0,0,0,0, 0, 8'h00, 0,0);
    vecs[1]  = mk(1,0,0,0, 1, 8'h00, 0,0);
    vecs[2]  = mk(1,1,0,0, 0, 8'h00, 0,0);
    vecs[3]  = mk(0,0,0,1, 0, 8'h00, 0,0);
    vecs[4]  = mk(1,0,0,1, 1, 8'h00, 0,1);
    vecs[5]  = mk(0,1,0,0, 1, 8'h00, 0,0);
    vecs[6]  = mk(0,0,0,0, 1, 8'h00, 0,0);
    vecs[7]  = mk(0,0,0,0, 1, 8'h00, 0,0);
    vecs[8]  = mk(0,1,0,0, 1, 8'h00, 0,0);
    vecs[9]  = mk(0,1,0,0, 1, 8'h00, 0,0);
    vecs[10] = mk(0,1,0,0, 1, 8'h00, 0,0);
    vecs[11] = mk(0,1,0,0, 1, 8'h00, 0,0);
    vecs[12] = mk(0,1,0,0, 1, 8'h01, 0,0);
    vecs[13] = mk(1,1,0,0, 1, 8'h01, 0,0);
    vecs[14] = mk(0,1,0,0, 1, 8'h01, 0,0);
    vecs[15] = mk(0,1,0,0, 1, 8'h01, 0,0);
    vecs[16] = mk(0,1,0,0, 1, 8'h01, 0,0);
    vecs[17] = mk(0,1,0,0, 1, 8'h00, 0,0);
    vecs[18] = mk(0,1,0,0, 0, 8'h00, 0,0);
    vecs[19] = mk(0,1,0,0, 0, 8'h00, 0,0);

    do_reset();
    chk("reset_outputs", 32'({pwr_up, ss_tmr, en_steer, ovr_alarm}), 32'd0);

    for (int i = 0; i < 20; i++) begin
      pwr_btn = vecs[i].btn; rider_on = vecs[i].rider;
      steer_ok = vecs[i].steer; too_fast = vecs[i].tf;
      cyc();
      chk($sformatf("vec%0d", i), 32'({pwr_up, ss_tmr, en_steer, ovr_alarm}),
          32'({vecs[i].pwr, vecs[i].ss, vecs[i].en, vecs[i].al}));
    end

    // Full ramp up to RUN
    do_reset();
    pwr_btn = 1'b1; rider_on = 1'b1;
    cyc();
    pwr_btn = 1'b0;
    chk("wait_pwr_up", 32'(pwr_up), 32'd1);
    cyc();
    chk("ramp_up_entry_ss", 32'(ss_tmr), 32'h00);
    wait_ss(8'hFF, 1100, n, ok);
    chk("ramp_up_clks", n, 1020);
    chk("ramp_up_pwr_held", 32'(ok), 32'd1);
    cyc();
    chk("run_ss_full", 32'(ss_tmr), 32'hFF);

    // Steering qualification and overspeed
    steer_ok = 1'b1;
    n = 0;
    while (en_steer !== 1'b1 && n < 50) begin cyc(); n++; end
    chk("steer_qual_clks", n, 8);
    too_fast = 1'b1;
    cyc();
    chk("ovr_alarm_rise", 32'(ovr_alarm), 32'd1);
    chk("en_steer_drop", 32'(en_steer), 32'd0);
    too_fast = 1'b0;
    cyc();
    chk("ovr_alarm_clear", 32'(ovr_alarm), 32'd0);
    chk("en_steer_recover", 32'(en_steer), 32'd1);

    // Power-off from RUN
    steer_ok = 1'b0;
    pwr_btn = 1'b1;
    cyc();
    pwr_btn = 1'b0;
    chk("dn_start_ss", 32'(ss_tmr), 32'hFF);
    chk("dn_en_steer", 32'(en_steer), 32'd0);
    wait_ss(8'h00, 1100, n, ok);
    chk("ramp_dn_clks", n, 1020);
    chk("ramp_dn_pwr_held", 32'(ok), 32'd1);
    cyc();
    chk("off_after_dn", 32'(pwr_up), 32'd0);
    cyc();
    chk("off_stays", 32'({pwr_up, ss_tmr}), 32'd0);

    // Rider leaves mid ramp-up, returns briefly during ramp-down
    pwr_btn = 1'b1;
    cyc();
    pwr_btn = 1'b0;
    cyc();
    wait_ss(8'h40, 400, n, ok);
    chk("reach_40_clks", n, 256);
    rider_on = 1'b0;
    cyc();
    chk("dn_from_up_ss", 32'(ss_tmr), 32'h40);
    n = 0; ok = 1'b1; prev = ss_tmr;
    while (ss_tmr !== 8'h00 && n < 400) begin
      if (n == 100) rider_on = 1'b1;
      if (n == 110) rider_on = 1'b0;
      cyc();
      n++;
      if (pwr_up !== 1'b1 || ss_tmr > prev) ok = 1'b0;
      prev = ss_tmr;
    end
    chk("dn_40_clks", n, 256);
    chk("dn_40_monotonic_pwr", 32'(ok), 32'd1);
    cyc();
    chk("wait_after_dn_pwr", 32'({pwr_up, ss_tmr}), 32'h100);

    // Button and rider together in WAIT
    pwr_btn = 1'b1; rider_on = 1'b1;
    cyc();
    pwr_btn = 1'b0;
    chk("wait_btn_priority", 32'(pwr_up), 32'd0);
    cyc();
    chk("wait_btn_off_stays", 32'({pwr_up, ss_tmr}), 32'd0);

    // Asynchronous reset mid-ramp
    pwr_btn = 1'b1;
    cyc();
    pwr_btn = 1'b0;
    cyc();
    wait_ss(8'h80, 600, n, ok);
    chk("reach_80_clks", n, 512);
    too_fast = 1'b1;
    cyc();
    chk("pre_reset_alarm", 32'(ovr_alarm), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({pwr_up, ss_tmr, en_steer, ovr_alarm}), 32'd0);
    too_fast = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    chk("post_reset_stays_off", 32'({pwr_up, ss_tmr, en_steer, ovr_alarm}), 32'd0);

    // Randomized run against the model
    do_reset();
    model_reset();
    rider_on = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      pwr_btn = ($urandom_range(199) == 0);
      if ($urandom_range(499) == 0) rider_on = ~rider_on;
      if ($urandom_range(29) == 0) steer_ok = ~steer_ok;
      too_fast = ($urandom_range(39) == 0);
      model_step();
      cyc();
      chk($sformatf("rand%0d", i), 32'({pwr_up, ss_tmr, en_steer, ovr_alarm}),
          32'({m_pwr, m_lvl[7:0], m_en, m_al}));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
